b2_mux_3_1_rr_sel: RTL and testbench



---
 rtl/b2_mux_3_1_rr_sel_pkg.sv | 33 +++
 rtl/b2_mux_3_1_rr_sel_if.sv | 13 +
 rtl/b2_mux_3_1_rr_pick3.sv | 33 +++
 rtl/b2_mux_3_1_rr_sel.sv | 140 ++++++++++++++
 tb/tb_b2_mux_3_1_rr_sel.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/b2_mux_3_1_rr_sel_pkg.sv
// Shared constants, state encoding and select helpers for the 3:1 mux round-robin select generator.
// RR_SEL_STATS_EN (optional) adds per-source accepted-transfer counters in the top.
package b2_mux_pkg;

    localparam logic [1:0] SEL_D0  = 2'b00;
    localparam logic [1:0] SEL_D1  = 2'b01;
    localparam logic [1:0] SEL_D2  = 2'b10;
    localparam int         STATS_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01
    } state_e;

    // Pointer handoff: the slot after the current owner, wrapping 2 -> 0.
    function automatic logic [1:0] next_ptr(input logic [1:0] s);
        case (s)
            SEL_D0:  return SEL_D1;
            SEL_D1:  return SEL_D2;
            default: return SEL_D0;
        endcase
    endfunction

    function automatic logic [2:0] sel_onehot(input logic [1:0] s);
        case (s)
            SEL_D0:  return 3'b001;
            SEL_D1:  return 3'b010;
            SEL_D2:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/b2_mux_3_1_rr_sel_if.sv
// Request/select bus between the requesters, the select generator and the downstream 3:1 mux.
interface b2_mux_3_1_rr_sel_if;

    logic [2:0] req;
    logic       rdy;
    logic [1:0] sel;
    logic       vld;
    logic [2:0] gnt;

    modport master (output req, output rdy, input sel, input vld, input gnt);
    modport slave  (input req, input rdy, output sel, output vld, output gnt);

endinterface

// File: rtl/b2_mux_3_1_rr_pick3.sv
// Combinational rotating-priority pick among three requesters, starting at ptr_i.
module rr_pick3
    import b2_mux_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] win_o,
    output logic       any_o
);

    always_comb begin
        any_o = |req_i;
        win_o = SEL_D0;
        case (ptr_i)
            SEL_D1: begin
                if      (req_i[1]) win_o = SEL_D1;
                else if (req_i[2]) win_o = SEL_D2;
                else if (req_i[0]) win_o = SEL_D0;
            end
            SEL_D2: begin
                if      (req_i[2]) win_o = SEL_D2;
                else if (req_i[0]) win_o = SEL_D0;
                else if (req_i[1]) win_o = SEL_D1;
            end
            default: begin
                if      (req_i[0]) win_o = SEL_D0;
                else if (req_i[1]) win_o = SEL_D1;
                else if (req_i[2]) win_o = SEL_D2;
            end
        endcase
    end

endmodule

// File: rtl/b2_mux_3_1_rr_sel.sv
// Round-robin arbiter driving the 2-bit select of a 3:1 mux; code 2'b11 is never produced.
// Define RR_SEL_STATS_EN to add saturating per-source accepted-transfer counters.
module b2_mux_3_1_rr_sel
    import b2_mux_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    b2_mux_3_1_rr_sel_if.slave       bus
`ifdef RR_SEL_STATS_EN
    ,
    input  logic                     clr_stats,
    output logic [STATS_W-1:0]       cnt0,
    output logic [STATS_W-1:0]       cnt1,
    output logic [STATS_W-1:0]       cnt2
`endif
);

    localparam logic [4:0] BURST_LIM = 5'(BURST_LEN);

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       vld_q, vld_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] bcnt_q, bcnt_d;

    logic [1:0] pick_ptr;
    logic [1:0] win;
    logic       any_req;
    logic       accept;
    logic       own_req;

    assign accept  = (state_q == GRANT) && vld_q && bus.rdy;
    assign own_req = |(bus.req & sel_onehot(sel_q));

    // One picker serves both the idle pick and the back-to-back handoff pick.
    assign pick_ptr = (state_q == GRANT) ? next_ptr(sel_q) : ptr_q;

    rr_pick3 u_pick (
        .req_i (bus.req),
        .ptr_i (pick_ptr),
        .win_o (win),
        .any_o (any_req)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                if (any_req) begin
                    state_d = GRANT;
                    sel_d   = win;
                    vld_d   = 1'b1;
                    bcnt_d  = 4'd0;
                end
            end
            GRANT: begin
                vld_d = 1'b1;
                if (accept) begin
                    if (own_req && (({1'b0, bcnt_q} + 5'd1) < BURST_LIM)) begin
                        bcnt_d = bcnt_q + 4'd1;
                    end else begin
                        ptr_d  = next_ptr(sel_q);
                        bcnt_d = 4'd0;
                        if (any_req) begin
                            sel_d = win;
                        end else begin
                            state_d = IDLE;
                            vld_d   = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                bcnt_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= SEL_D0;
            vld_q   <= 1'b0;
            ptr_q   <= SEL_D0;
            bcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign bus.sel = sel_q;
    assign bus.vld = vld_q;
    assign bus.gnt = vld_q ? sel_onehot(sel_q) : 3'b000;

`ifdef RR_SEL_STATS_EN
    logic [STATS_W-1:0] cnt_q [3];
    logic [STATS_W-1:0] cnt_d [3];
    logic [2:0]         acc_src;

    assign acc_src = accept ? sel_onehot(sel_q) : 3'b000;

    // Clear wins over a coincident increment; counters stick at all-ones.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_stats) begin
                cnt_d[i] = '0;
            end else if (acc_src[i] && (cnt_q[i] != {STATS_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
`endif

endmodule

// File: tb/tb_b2_mux_3_1_rr_sel.sv
// Directed bench for b2_mux_3_1_rr_sel: three instances cover BURST_LEN = 4, 1 and 3.
module tb_b2_mux_3_1_rr_sel;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    b2_mux_3_1_rr_sel_if bus_a ();
    b2_mux_3_1_rr_sel_if bus_b ();
    b2_mux_3_1_rr_sel_if bus_c ();

`ifdef RR_SEL_STATS_EN
    logic       clr_a = 1'b0;
    logic [7:0] a_cnt0, a_cnt1, a_cnt2;
    logic [7:0] b_cnt0, b_cnt1, b_cnt2;
    logic [7:0] c_cnt0, c_cnt1, c_cnt2;

    b2_mux_3_1_rr_sel #(.BURST_LEN(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a),
        .clr_stats(clr_a), .cnt0(a_cnt0), .cnt1(a_cnt1), .cnt2(a_cnt2));
    b2_mux_3_1_rr_sel #(.BURST_LEN(1)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b),
        .clr_stats(1'b0), .cnt0(b_cnt0), .cnt1(b_cnt1), .cnt2(b_cnt2));
    b2_mux_3_1_rr_sel #(.BURST_LEN(3)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c),
        .clr_stats(1'b0), .cnt0(c_cnt0), .cnt1(c_cnt1), .cnt2(c_cnt2));
`else
    b2_mux_3_1_rr_sel #(.BURST_LEN(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    b2_mux_3_1_rr_sel #(.BURST_LEN(1)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    b2_mux_3_1_rr_sel #(.BURST_LEN(3)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        bus_a.req = 3'b000; bus_a.rdy = 1'b0;
        bus_b.req = 3'b000; bus_b.rdy = 1'b0;
        bus_c.req = 3'b000; bus_c.rdy = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [1:0] rr_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [1:0] bu_exp [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};

    initial begin
        reset_all();
        chk("rst_sel", 32'(bus_a.sel), 32'd0);
        chk("rst_vld", 32'(bus_a.vld), 32'd0);
        chk("rst_gnt", 32'(bus_a.gnt), 32'd0);

        // Single requester, BURST_LEN=4: sole requester keeps the mux with no bubble.
        bus_a.req = 3'b010; bus_a.rdy = 1'b1;
        step();
        chk("single_vld", 32'(bus_a.vld), 32'd1);
        chk("single_sel", 32'(bus_a.sel), 32'd1);
        chk("single_gnt", 32'(bus_a.gnt), 32'b010);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("single_hold_sel", 32'(bus_a.sel), 32'd1);
            chk("single_hold_vld", 32'(bus_a.vld), 32'd1);
        end

        // Round-robin fairness, BURST_LEN=1.
        bus_b.req = 3'b111; bus_b.rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_sel", 32'(bus_b.sel), 32'(rr_exp[i]));
            chk("rr_vld", 32'(bus_b.vld), 32'd1);
        end

        // Burst vs priority, BURST_LEN=3.
        bus_c.req = 3'b011; bus_c.rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("burst_sel", 32'(bus_c.sel), 32'(bu_exp[i]));
        end

        // Backpressure with the owner dropping its request.
        reset_all();
        bus_a.req = 3'b100; bus_a.rdy = 1'b0;
        step();
        chk("bp_grant_sel", 32'(bus_a.sel), 32'd2);
        chk("bp_grant_vld", 32'(bus_a.vld), 32'd1);
        bus_a.req = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_sel", 32'(bus_a.sel), 32'd2);
            chk("bp_hold_vld", 32'(bus_a.vld), 32'd1);
            chk("bp_hold_gnt", 32'(bus_a.gnt), 32'b100);
        end
        bus_a.rdy = 1'b1;
        step();
        chk("bp_idle_vld", 32'(bus_a.vld), 32'd0);
        chk("bp_idle_gnt", 32'(bus_a.gnt), 32'd0);
        step();
        chk("bp_idle_vld2", 32'(bus_a.vld), 32'd0);

        // Asynchronous reset in the middle of a grant on sel=2'b10.
        bus_a.req = 3'b100; bus_a.rdy = 1'b0;
        step();
        chk("mid_pre_sel", 32'(bus_a.sel), 32'd2);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_sel", 32'(bus_a.sel), 32'd0);
        chk("mid_rst_vld", 32'(bus_a.vld), 32'd0);
        chk("mid_rst_gnt", 32'(bus_a.gnt), 32'd0);
        bus_a.req = 3'b000;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_vld", 32'(bus_a.vld), 32'd0);
        end

`ifdef RR_SEL_STATS_EN
        reset_all();
        bus_a.req = 3'b001; bus_a.rdy = 1'b1;
        step();
        for (int i = 0; i < 302; i++) step();
        chk("stat_cnt0_sat", 32'(a_cnt0), 32'hFF);
        chk("stat_cnt1", 32'(a_cnt1), 32'd0);
        chk("stat_cnt2", 32'(a_cnt2), 32'd0);
        clr_a = 1'b1;
        step();
        chk("stat_clr", 32'(a_cnt0), 32'd0);
        clr_a = 1'b0;
        step();
        chk("stat_after_clr", 32'(a_cnt0), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
